// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right, shift left, parallel load.
// Serial-in bits come from the parallel data input (MSB for right, LSB for left).
module universal_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_SHR   = 2'd1,
    MODE_SHL   = 2'd2,
    MODE_LOAD  = 2'd3
  } mode_e;

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;

  // An unknown ctrl value matches no item and falls through to hold.
  always_comb begin
    dout_d = dout_q;
    case (ctrl)
      MODE_HOLD: dout_d = dout_q;
      MODE_SHR:  dout_d = {data[WIDTH-1], dout_q[WIDTH-1:1]};
      MODE_SHL:  dout_d = {dout_q[WIDTH-2:0], data[0]};
      MODE_LOAD: dout_d = data;
      default:   dout_d = dout_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: vector table, directed reset
// sequences and a random run, all checked through an expected-value queue.
module tb_universal_shift_reg;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   ctrl;
  logic [W-1:0] data;
  logic [W-1:0] dout;

  int total;
  int bad;

  typedef struct {
    string      name;
    logic [1:0] ctrl;
    logic [3:0] data;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } sb_t;

  sb_t        sb_q[$];
  logic [3:0] model_q;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl),
    .data (data),
    .dout (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: dout=%b expected=%b", name, act, exp);
    end
  endtask

  // Independent reference: builds the next value bit by bit.
  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic [1:0] c,
                                            input logic [3:0] d);
    logic [3:0] r;
    r = cur;
    if (c == 2'd1) begin
      for (int i = 0; i < 3; i++) r[i] = cur[i+1];
      r[3] = d[3];
    end else if (c == 2'd2) begin
      for (int i = 3; i > 0; i--) r[i] = cur[i-1];
      r[0] = d[0];
    end else if (c == 2'd3) begin
      r = d;
    end
    return r;
  endfunction

  // Drive on the falling edge, queue the expectation, compare just after the rising edge.
  task automatic step(input string name, input logic [1:0] c, input logic [3:0] d,
                      input logic [3:0] exp);
    sb_t e;
    @(negedge clk);
    ctrl = c;
    data = d;
    sb_q.push_back('{name: name, exp: exp});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty expected=%b", name, exp);
    end else begin
      e = sb_q.pop_front();
      check(e.name, dout, e.exp);
    end
    model_q = exp;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{name: "hold0",   ctrl: 2'd0, data: 4'd1,  exp: 4'b0000};
    tbl[1] = '{name: "hold1",   ctrl: 2'd0, data: 4'd1,  exp: 4'b0000};
    tbl[2] = '{name: "hold2",   ctrl: 2'd0, data: 4'd1,  exp: 4'b0000};
    tbl[3] = '{name: "load12",  ctrl: 2'd3, data: 4'd12, exp: 4'b1100};
    tbl[4] = '{name: "shr_in1", ctrl: 2'd1, data: 4'd10, exp: 4'b1110};
    tbl[5] = '{name: "shr_in0", ctrl: 2'd1, data: 4'd1,  exp: 4'b0111};
    tbl[6] = '{name: "shl_in1", ctrl: 2'd2, data: 4'd11, exp: 4'b1111};
    tbl[7] = '{name: "shl_in0", ctrl: 2'd2, data: 4'd12, exp: 4'b1110};

    total   = 0;
    bad     = 0;
    model_q = '0;
    rst     = 1'b1;
    ctrl    = 2'd0;
    data    = '0;

    #1;
    check("reset_initial", dout, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Async reset between edges with a non-zero register.
    step("load10", 2'd3, 4'd10, 4'b1010);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", dout, 4'b0000);
    ctrl = 2'd3;
    data = 4'd15;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_held", dout, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    ctrl = 2'd0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].name, tbl[i].ctrl, tbl[i].data, tbl[i].exp);
    end

    // Mid-operation reset during alternating load / shift-left.
    step("mid_load9a", 2'd3, 4'd9, 4'b1001);
    step("mid_shl_a",  2'd2, 4'd0, 4'b0010);
    step("mid_load9b", 2'd3, 4'd9, 4'b1001);
    step("mid_shl_b",  2'd2, 4'd1, 4'b0011);
    @(negedge clk);
    ctrl = 2'd2;
    data = 4'd1;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_immediate", dout, 4'b0000);
    #1;
    rst = 1'b0;
    model_q = '0;
    step("post_rst_load5", 2'd3, 4'd5, 4'd5);

    // WIDTH shifts leave only serial-in bits; rotate by feeding back the outgoing bit.
    step("fill_shl0", 2'd2, 4'b0001, 4'b1011);
    step("fill_shl1", 2'd2, 4'b1110, 4'b0110);
    step("fill_shl2", 2'd2, 4'b0001, 4'b1101);
    step("fill_shl3", 2'd2, 4'b0000, 4'b1010);
    step("rotr", 2'd1, {model_q[0], 3'b000}, 4'b0101);
    step("rotr2", 2'd1, {model_q[0], 3'b011}, 4'b1010);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] c;
      logic [3:0] d;
      c = 2'($urandom_range(0, 3));
      d = 4'($urandom_range(0, 15));
      step("random", c, d, model_next(model_q, c, d));
    end

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
